// File: rtl/fe_mul_sequencer.sv
// Schedule-ROM driven 5x5-limb schoolbook multiply; returns 9 raw column accumulators.
// Build option FE_MUL_FOLD_EN adds one FOLD cycle: col[c] += 19*col[c+5] (c=0..3), col[5..8] cleared.
module fe_mul_sequencer #(
    parameter int LIMB_W = 51,
    parameter int ACC_W  = 112
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [5*LIMB_W-1:0] req_a,
    input  logic [5*LIMB_W-1:0] req_b,
    output logic [4:0]          sched_k,
    input  logic [2:0]          sched_i,
    input  logic [2:0]          sched_j,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [9*ACC_W-1:0]  res_col,
    output logic                busy,
    output logic                sched_err
);

`ifdef FE_MUL_FOLD_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FOLD = 2'd2, S_DONE = 2'd3} state_t;
    localparam logic [ACC_W-1:0] FOLD_K = {{(ACC_W-5){1'b0}}, 5'd19};
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t                     state_r;
    state_t                     state_s;
    logic [5*LIMB_W-1:0]        a_r;
    logic [5*LIMB_W-1:0]        b_r;
    logic [8:0][ACC_W-1:0]      col_r;
    logic [4:0]                 k_r;
    logic                       req_ready_r;
    logic                       res_valid_r;
    logic                       busy_r;
    logic                       sched_err_r;

    logic                       idx_ok_s;
    logic [3:0]                 col_idx_s;
    logic [LIMB_W-1:0]          a_limb_s;
    logic [LIMB_W-1:0]          b_limb_s;
    logic [2*LIMB_W-1:0]        prod_full_s;
    logic [ACC_W-1:0]           prod_s;

    // Out-of-range ROM indices select zero so the guarded datapath never sees X.
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [5*LIMB_W-1:0] vec,
                                                   input logic [2:0] idx);
        case (idx)
            3'd0:    limb_sel = vec[0*LIMB_W +: LIMB_W];
            3'd1:    limb_sel = vec[1*LIMB_W +: LIMB_W];
            3'd2:    limb_sel = vec[2*LIMB_W +: LIMB_W];
            3'd3:    limb_sel = vec[3*LIMB_W +: LIMB_W];
            3'd4:    limb_sel = vec[4*LIMB_W +: LIMB_W];
            default: limb_sel = {LIMB_W{1'b0}};
        endcase
    endfunction

    // Partial product for the current schedule step.
    always_comb begin
        idx_ok_s    = (sched_i <= 3'd4) && (sched_j <= 3'd4);
        col_idx_s   = {1'b0, sched_i} + {1'b0, sched_j};
        a_limb_s    = limb_sel(a_r, sched_i);
        b_limb_s    = limb_sel(b_r, sched_j);
        prod_full_s = {{LIMB_W{1'b0}}, a_limb_s} * {{LIMB_W{1'b0}}, b_limb_s};
        prod_s      = {{(ACC_W-2*LIMB_W){1'b0}}, prod_full_s};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_s = S_MUL;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (k_r == 5'd24) begin
`ifdef FE_MUL_FOLD_EN
                    state_s = S_FOLD;
`else
                    state_s = S_DONE;
`endif
                end else begin
                    state_s = S_MUL;
                end
            end
`ifdef FE_MUL_FOLD_EN
            S_FOLD: begin
                state_s = S_DONE;
            end
`endif
            S_DONE: begin
                // A take is only honoured once res_valid is actually visible.
                if (res_valid_r && res_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Operand latch, column accumulation, optional fold, sticky schedule error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            col_r       <= '0;
            k_r         <= 5'd0;
            sched_err_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        a_r   <= req_a;
                        b_r   <= req_b;
                        col_r <= '0;
                        k_r   <= 5'd0;
                    end
                end
                S_MUL: begin
                    for (int c = 0; c < 9; c++) begin
                        if (idx_ok_s && (col_idx_s == 4'(c))) begin
                            col_r[c] <= col_r[c] + prod_s;
                        end
                    end
                    if (!idx_ok_s) begin
                        sched_err_r <= 1'b1;
                    end
                    k_r <= (k_r == 5'd24) ? 5'd0 : k_r + 5'd1;
                end
`ifdef FE_MUL_FOLD_EN
                S_FOLD: begin
                    for (int c = 0; c < 4; c++) begin
                        col_r[c] <= col_r[c] + FOLD_K * col_r[c+5];
                    end
                    for (int c = 5; c < 9; c++) begin
                        col_r[c] <= '0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Handshake and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            req_ready_r <= (state_s == S_IDLE);
            res_valid_r <= (state_r == S_DONE) && !(res_valid_r && res_ready);
            busy_r      <= (state_s != S_IDLE);
        end
    end

    assign req_ready = req_ready_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
    assign sched_err = sched_err_r;
    assign sched_k   = k_r;
    assign res_col   = col_r;

endmodule
